// File: rtl/gauss_kernel5_pkg.sv
// Shared constants and FSM state type for the 5x5 binomial Gaussian kernel.
// Rounding mode is selected elsewhere by GAUSS_KERNEL_ROUND_EN.
package gauss_kernel5_pkg;
   localparam int unsigned COLS_DEF  = 640;
   localparam int unsigned COL_W_DEF = 13;
   localparam int unsigned PIX_W_DEF = 8;
   localparam int unsigned V_W       = 12;
   localparam int unsigned H_W       = 16;
   localparam int unsigned NCH       = 3;
   localparam int unsigned FLUSH_CNT = 2;
   localparam int unsigned W_EDGE    = 1;
   localparam int unsigned W_MID     = 4;
   localparam int unsigned W_CTR     = 6;

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_e;
endpackage

// File: rtl/gauss_kernel5_if.sv
// Column-tap input and filtered-pixel output bundle of gauss_kernel5.
interface gauss_kernel5_if #(
   parameter int unsigned COL_W = 13,
   parameter int unsigned PIX_W = 8
);
   logic               in_valid;
   logic [COL_W-1:0]   col;
   logic               filt_sel;
   logic [5*PIX_W-1:0] tap_r;
   logic [5*PIX_W-1:0] tap_g;
   logic [5*PIX_W-1:0] tap_b;
   logic               out_valid;
   logic [COL_W-1:0]   out_col;
   logic [PIX_W-1:0]   out_r;
   logic [PIX_W-1:0]   out_g;
   logic [PIX_W-1:0]   out_b;
   logic               err;

   modport master (
      output in_valid, col, filt_sel, tap_r, tap_g, tap_b,
      input  out_valid, out_col, out_r, out_g, out_b, err
   );
   modport slave (
      input  in_valid, col, filt_sel, tap_r, tap_g, tap_b,
      output out_valid, out_col, out_r, out_g, out_b, err
   );
endinterface

// File: rtl/gauss_kernel5_binom5.sv
// Combinational 1-4-6-4-1 weighted sum of five IN_W-bit samples, shift-add only.
module gauss_binom5 #(
   parameter int unsigned IN_W = 8
) (
   input  logic [5*IN_W-1:0] x,
   output logic [IN_W+3:0]   y
);
   localparam int unsigned OW = IN_W + 4;

   logic [OW-1:0] e [5];

   always_comb begin
      for (int unsigned i = 0; i < 5; i++) begin
         e[i] = OW'(x[i*IN_W +: IN_W]);
      end
      y = e[0] + e[4] + ((e[1] + e[3]) << 2) + (e[2] << 2) + (e[2] << 1);
   end
endmodule

// File: rtl/gauss_kernel5.sv
// Separable 5x5 binomial Gaussian on RGB column taps with edge replication.
// GAUSS_KERNEL_ROUND_EN selects round-half-up; otherwise the result is truncated.
module gauss_kernel5
   import gauss_kernel5_pkg::*;
#(
   parameter int unsigned COLS  = COLS_DEF,
   parameter int unsigned COL_W = COL_W_DEF,
   parameter int unsigned PIX_W = PIX_W_DEF
) (
   input logic            clk,
   input logic            rst_n,
   gauss_kernel5_if.slave bus
);
   localparam int unsigned VW  = PIX_W + 4;
   localparam int unsigned HW  = VW + 4;
   localparam int unsigned HW1 = HW + 1;
   localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
   localparam logic [COL_W-1:0] FLUSH_COL = COL_W'(COLS - FLUSH_CNT);
   localparam logic [HW:0]      PIX_MAX   = HW1'((1 << PIX_W) - 1);
`ifdef GAUSS_KERNEL_ROUND_EN
   localparam logic [HW:0]      RND       = HW1'(1 << (HW - PIX_W - 1));
`else
   localparam logic [HW:0]      RND       = '0;
`endif

   logic [NCH-1:0][5*PIX_W-1:0]    taps;
   logic [NCH-1:0][VW-1:0]         v_c, v_d, v_q;
   logic [NCH-1:0][PIX_W-1:0]      raw_d, raw_q;
   logic                           s1_valid_d, s1_valid_q;
   logic [COL_W-1:0]               s1_col_d, s1_col_q;
   state_e                         state_d, state_q;
   logic [COL_W-1:0]               prev_d, prev_q;
   logic                           fcnt_d, fcnt_q;
   logic [NCH-1:0][4:0][VW-1:0]    w_d, w_q;
   logic [NCH-1:0][4:0][PIX_W-1:0] rw_d, rw_q;
   logic [NCH-1:0][HW-1:0]         h_c, h_d, h_q;
   logic [NCH-1:0][PIX_W-1:0]      rc_d, rc_q;
   logic                           s2_valid_d, s2_valid_q;
   logic [COL_W-1:0]               s2_col_d, s2_col_q;
   logic                           load, shift, flush_shift;
   logic                           err_d, err_q;
   logic [NCH-1:0][HW:0]           sum_c, div_c;
   logic                           out_valid_d, out_valid_q;
   logic [COL_W-1:0]               out_col_d, out_col_q;
   logic [NCH-1:0][PIX_W-1:0]      out_pix_d, out_pix_q;

   assign taps = {bus.tap_b, bus.tap_g, bus.tap_r};

   // Horizontal sum sees the post-shift window so S2 adds no extra cycle.
   for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
      gauss_binom5 #(.IN_W(PIX_W)) u_vert (.x(taps[ch]), .y(v_c[ch]));
      gauss_binom5 #(.IN_W(VW))    u_horz (.x(w_d[ch]),  .y(h_c[ch]));
   end

   always_comb begin
      s1_valid_d = bus.in_valid;
      s1_col_d   = bus.col;
      v_d        = v_c;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
         raw_d[ch] = taps[ch][2*PIX_W +: PIX_W];
      end
   end

   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      fcnt_d      = fcnt_q;
      err_d       = err_q;
      s2_valid_d  = 1'b0;
      s2_col_d    = s2_col_q;
      load        = 1'b0;
      shift       = 1'b0;
      flush_shift = 1'b0;
      case (state_q)
         IDLE: begin
            if (s1_valid_q && s1_col_q == '0) begin
               load    = 1'b1;
               prev_d  = '0;
               state_d = FILL;
            end
         end
         FILL, RUN: begin
            if (s1_valid_q) begin
               if (s1_col_q == prev_q + 1'b1) begin
                  shift  = 1'b1;
                  prev_d = s1_col_q;
                  if (state_q == FILL) begin
                     state_d = RUN;
                  end else begin
                     s2_valid_d = 1'b1;
                     s2_col_d   = s1_col_q - COL_W'(2);
                     if (s1_col_q == LAST_COL) begin
                        state_d = FLUSH;
                        fcnt_d  = 1'b0;
                     end
                  end
               end else begin
                  err_d = 1'b1;
                  if (s1_col_q == '0) begin
                     load    = 1'b1;
                     prev_d  = '0;
                     state_d = FILL;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         FLUSH: begin
            flush_shift = 1'b1;
            s2_valid_d  = 1'b1;
            s2_col_d    = FLUSH_COL + COL_W'(fcnt_q);
            fcnt_d      = fcnt_q + 1'b1;
            if (s1_valid_q) err_d = 1'b1;
            if (fcnt_q == 1'(FLUSH_CNT - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      w_d  = w_q;
      rw_d = rw_q;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
         if (load) begin
            w_d[ch]  = {5{v_q[ch]}};
            rw_d[ch] = {5{raw_q[ch]}};
         end else if (shift) begin
            w_d[ch]  = {v_q[ch], w_q[ch][4:1]};
            rw_d[ch] = {raw_q[ch], rw_q[ch][4:1]};
         end else if (flush_shift) begin
            w_d[ch]  = {w_q[ch][4], w_q[ch][4:1]};
            rw_d[ch] = {rw_q[ch][4], rw_q[ch][4:1]};
         end
         rc_d[ch] = rw_d[ch][2];
      end
      h_d = h_c;
   end

   always_comb begin
      out_valid_d = s2_valid_q;
      out_col_d   = out_col_q;
      out_pix_d   = out_pix_q;
      sum_c       = '0;
      div_c       = '0;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
         sum_c[ch] = {1'b0, h_q[ch]} + RND;
         div_c[ch] = sum_c[ch] >> (HW - PIX_W);
      end
      if (s2_valid_q) begin
         out_col_d = s2_col_q;
         for (int unsigned ch = 0; ch < NCH; ch++) begin
            if (!bus.filt_sel)            out_pix_d[ch] = rc_q[ch];
            else if (div_c[ch] > PIX_MAX) out_pix_d[ch] = '1;
            else                          out_pix_d[ch] = div_c[ch][PIX_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_col_q    <= '0;
         v_q         <= '0;
         raw_q       <= '0;
         state_q     <= IDLE;
         prev_q      <= '0;
         fcnt_q      <= 1'b0;
         w_q         <= '0;
         rw_q        <= '0;
         h_q         <= '0;
         rc_q        <= '0;
         s2_valid_q  <= 1'b0;
         s2_col_q    <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_col_q   <= '0;
         out_pix_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_col_q    <= s1_col_d;
         v_q         <= v_d;
         raw_q       <= raw_d;
         state_q     <= state_d;
         prev_q      <= prev_d;
         fcnt_q      <= fcnt_d;
         w_q         <= w_d;
         rw_q        <= rw_d;
         h_q         <= h_d;
         rc_q        <= rc_d;
         s2_valid_q  <= s2_valid_d;
         s2_col_q    <= s2_col_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         out_col_q   <= out_col_d;
         out_pix_q   <= out_pix_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_col   = out_col_q;
   assign bus.out_r     = out_pix_q[0];
   assign bus.out_g     = out_pix_q[1];
   assign bus.out_b     = out_pix_q[2];
   assign bus.err       = err_q;
endmodule
